// File: rtl/aes_pkg.sv
// AES shared types, GF(2^8) helpers, S-boxes and key-schedule steps.
// Byte (row r, col c) of a block sits at index 15-(4*r+c).
package aes_pkg;

  typedef logic [15:0][7:0] aes_block_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(
    input logic [7:0] x,
    input int k
  );
    return (x << k) | (x >> (8 - k));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3)
      ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  // column word, row 0 in the top byte
  function automatic logic [31:0] col(
    input aes_block_t b,
    input int c
  );
    return {b[15-c], b[11-c], b[7-c], b[3-c]};
  endfunction

  function automatic aes_block_t blk(input logic [3:0][31:0] w);
    aes_block_t b;
    b = '0;
    for (int c = 0; c < 4; c++) begin
      b[15-c] = w[c][31:24];
      b[11-c] = w[c][23:16];
      b[7-c]  = w[c][15:8];
      b[3-c]  = w[c][7:0];
    end
    return b;
  endfunction

  function automatic logic [31:0] subrot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]),
            sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic aes_block_t key_fwd(
    input aes_block_t k,
    input logic [7:0] rc
  );
    logic [31:0] w0, w1, w2, w3;
    w0 = col(k, 0) ^ subrot(col(k, 3)) ^ {rc, 24'h0};
    w1 = col(k, 1) ^ w0;
    w2 = col(k, 2) ^ w1;
    w3 = col(k, 3) ^ w2;
    return blk({w3, w2, w1, w0});
  endfunction

  function automatic aes_block_t key_inv(
    input aes_block_t k,
    input logic [7:0] rc
  );
    logic [31:0] w0, w1, w2, w3;
    w3 = col(k, 3) ^ col(k, 2);
    w2 = col(k, 2) ^ col(k, 1);
    w1 = col(k, 1) ^ col(k, 0);
    w0 = col(k, 0) ^ subrot(w3) ^ {rc, 24'h0};
    return blk({w3, w2, w1, w0});
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
// Ports: data, rkey in; last bypasses InvMixColumns; nxt = result.
module aes_inv_round
  import aes_pkg::*;
(
  input  aes_block_t data,
  input  aes_block_t rkey,
  input  logic       last,
  output aes_block_t nxt
);

  aes_block_t      sr, ak, mc;
  logic [3:0][7:0] a;

  always_comb begin
    sr = '0;
    mc = '0;
    a  = '0;
    // row r rotates right by r
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sr[15-(4*r+c)] = inv_sbox(data[15-(4*r+((c-r+4)%4))]);
    ak = sr ^ rkey;
    for (int c = 0; c < 4; c++) begin
      a[0] = ak[15-c];
      a[1] = ak[11-c];
      a[2] = ak[7-c];
      a[3] = ak[3-c];
      mc[15-c] = gmul(a[0], 8'h0e) ^ gmul(a[1], 8'h0b)
               ^ gmul(a[2], 8'h0d) ^ gmul(a[3], 8'h09);
      mc[11-c] = gmul(a[0], 8'h09) ^ gmul(a[1], 8'h0e)
               ^ gmul(a[2], 8'h0b) ^ gmul(a[3], 8'h0d);
      mc[7-c]  = gmul(a[0], 8'h0d) ^ gmul(a[1], 8'h09)
               ^ gmul(a[2], 8'h0e) ^ gmul(a[3], 8'h0b);
      mc[3-c]  = gmul(a[0], 8'h0b) ^ gmul(a[1], 8'h0d)
               ^ gmul(a[2], 8'h09) ^ gmul(a[3], 8'h0e);
    end
    nxt = last ? ak : mc;
  end

endmodule

// File: rtl/decrypt.sv
// Iterative AES-128 inverse cipher, one round per clock, key expanded on the fly.
// Ports: clk, reset, start, state, key in; ready, out, out_valid out.
module decrypt
  import aes_pkg::*;
#(
  parameter int NR = 10
)(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [15:0][7:0] state,
  input  logic [15:0][7:0] key,
  output logic            ready,
  output logic [15:0][7:0] out,
  output logic            out_valid
);

  if (NR != 10) begin : g_nr
    $error("decrypt: only NR=10 is supported");
  end

  typedef enum logic [2:0] {
    IDLE, KEYX, INIT, ROUND, FINAL, DONE
  } fsm_t;

  localparam logic [3:0] LASTK = 4'(NR - 1);

  fsm_t       fsm, fsm_n;
  aes_block_t data, data_n;
  aes_block_t kreg, kreg_n;
  aes_block_t out_n, rnd;
  logic [3:0] cnt, cnt_n;
  logic       ov_n;

  aes_inv_round u_round (
    .data (data),
    .rkey (kreg),
    .last (fsm == FINAL),
    .nxt  (rnd)
  );

  assign ready = (fsm == IDLE) || (fsm == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm       <= IDLE;
      data      <= '0;
      kreg      <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      fsm       <= fsm_n;
      data      <= data_n;
      kreg      <= kreg_n;
      cnt       <= cnt_n;
      out       <= out_n;
      out_valid <= ov_n;
    end
  end

  always_comb begin
    fsm_n  = fsm;
    data_n = data;
    kreg_n = kreg;
    cnt_n  = cnt;
    out_n  = out;
    ov_n   = out_valid;
    unique case (fsm)
      IDLE, DONE: begin
        if (start) begin
          data_n = state;
          kreg_n = key;
          cnt_n  = '0;
          ov_n   = 1'b0;
          fsm_n  = KEYX;
        end
      end
      KEYX: begin
        kreg_n = key_fwd(kreg, RCON[cnt + 4'd1]);
        cnt_n  = cnt + 4'd1;
        if (cnt == LASTK) fsm_n = INIT;
      end
      INIT: begin
        data_n = data ^ kreg;
        kreg_n = key_inv(kreg, RCON[4'(NR)]);
        cnt_n  = LASTK;
        fsm_n  = ROUND;
      end
      ROUND: begin
        data_n = rnd;
        kreg_n = key_inv(kreg, RCON[cnt]);
        cnt_n  = cnt - 4'd1;
        if (cnt == 4'd1) fsm_n = FINAL;
      end
      FINAL: begin
        out_n = rnd;
        ov_n  = 1'b1;
        fsm_n = DONE;
      end
      default: fsm_n = IDLE;
    endcase
  end

endmodule

// File: doc/decrypt.md
Name: decrypt

Overview:
- Iterative AES-128 inverse cipher; the counterpart of the encrypt block.
- Takes a 128-bit ciphertext and the original cipher key, and produces the plaintext.
- Uses the same byte-matrix layout as encrypt, so encrypt output can be fed straight back in for loopback checks.
- Does one round per clock and expands the key on the fly: forward to round key 10, then backward one round per cycle.

Parameters:
- NR, 10, number of rounds. Only 10 (AES-128) is legal; any other value is a static assertion failure.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only on a rising edge where ready=1.
- state  in  [15:0][7:0]  ciphertext, sampled on acceptance.
- key  in  [15:0][7:0]  cipher key (round key 0), sampled on acceptance.
- ready  out  1  high in IDLE and DONE.
- out  out  [15:0][7:0]  plaintext, valid while out_valid=1.
- out_valid  out  1  level; high from completion until the next start is accepted.

Behaviour:
- Byte layout (state, key, out): row-major with row 0 at the top. Index 15-(4*r+c) holds matrix byte (row r, col c). FIPS-197 stream byte n maps to r=n%4, c=n/4.
- Reset (asynchronous): FSM=IDLE, data/key/counter regs=0, out=0, out_valid=0, ready=1. Reset asserted mid-operation aborts the operation; no output is produced.
- FSM states: IDLE, KEYX, INIT, ROUND, FINAL, DONE.
- IDLE/DONE, start=1:
  - data<=state, kreg<=key, cnt<=0, out_valid<=0, go to KEYX.
  - In DONE, out keeps its old value until FINAL rewrites it.
- KEYX (10 cycles):
  - kreg<=forward key step(kreg, Rcon[cnt+1]), cnt++.
  - When cnt==9, go to INIT; kreg now holds round key 10.
- INIT (1 cycle): data<=data^kreg; kreg<=inverse key step(kreg, Rcon[10]); cnt<=9; go to ROUND.
- ROUND (9 cycles, cnt 9..1):
  - data<=InvMixColumns(InvSubBytes(InvShiftRows(data))^kreg).
  - kreg<=inverse key step(kreg, Rcon[cnt]); cnt--.
  - At cnt==1, go to FINAL; kreg now holds round key 0.
- FINAL (1 cycle): out<=InvSubBytes(InvShiftRows(data))^kreg; out_valid<=1; go to DONE.
- Latency: out_valid rises exactly 21 clocks after the accepting edge. Throughput is one block per 22 cycles if start is held high.
- start while busy (KEYX..FINAL) is ignored; state and key changes while busy have no effect.
- Inverse key step, using words w0..w3 where w0 = column 0:
  - w3'=w3^w2, w2'=w2^w1, w1'=w1^w0.
  - w0'=w0^SubWord(RotWord(w3'))^{Rcon,0,0,0}.
- All arithmetic is GF(2^8) with polynomial 0x11B. InvMixColumns coefficients are 0e/0b/0d/09.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package aes_pkg holds:
  - typedef aes_block_t = logic [15:0][7:0].
  - sbox and inv_sbox functions.
  - RCON[1:10] constant (01,02,04,08,10,20,40,80,1b,36).
  - xtime and gmul functions.
  - Forward and inverse key-step functions.
  - Shared with encrypt.
- One sub-module, aes_inv_round: combinational. Inputs data, rkey, last; output next data. When last=1, InvMixColumns is bypassed.

Test Plan:
1. FIPS-197 App. B inverse: key rows 2b28ab09/7eaef7cf/15d2154f/16a6883c; state rows 3902dc19/25dc116a/8409850b/1dfb9732 -> out rows 3288 31e0/435a3137/f6309807/a88d a234, i.e. out[15..0]=32,88,31,e0,43,5a,31,37,f6,30,98,07,a8,8d,a2,34; out_valid exactly 21 clocks after start.
2. FIPS-197 C.1: key 000102..0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a (stream order, mapped per layout) -> plaintext 00112233445566778899aabbccddeeff.
3. Zero key with ciphertext 66e94bd4ef8a2c3b884cfa59ca342b2e -> out all zeros; ready low for cycles 1..21 after acceptance.
4. Pulse start with garbage state/key at cycles 5 and 15 during test 1 -> result unchanged and latency still 21.
5. Assert reset at cycle 12 of an operation -> out=0, out_valid=0, ready=1 immediately (asynchronously); a fresh start then yields the correct result of test 2.
6. Hold start high through test 1 into test 2 -> out_valid drops on the second acceptance, then rises 21 cycles later with the test 2 plaintext; loopback of encrypt output returns the original plaintext.
